// File: rtl/vlane_div_unit.sv
// vlane_div_unit: iterative restoring divider for one vector lane.
// Executes vdivu/vdiv/vremu/vrem on SEW 8/16/32 elements, one quotient bit per cycle.
// Division by zero and signed overflow return RISC-V non-trapping results without iterating.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   start_div      one-cycle request, only accepted while idle
//   vs2_data       dividend (low SEW bits used)
//   vs1_data       divisor  (low SEW bits used)
//   div_type       0 = quotient, 1 = remainder
//   is_signed_div  1 = two's-complement operands
//   sew            00 = 8, 01 = 16, 10/11 = 32
//   wdata_du       result, zero above SEW; held until the next result or reset
//   busy_du        unit occupied (DIVIDE and DONE)
//   done_du        one-cycle result-valid pulse
//   exception_du   constant 0
module vlane_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_div,
  input  logic [WIDTH-1:0] vs2_data,
  input  logic [WIDTH-1:0] vs1_data,
  input  logic             div_type,
  input  logic             is_signed_div,
  input  logic [1:0]       sew,
  output logic [WIDTH-1:0] wdata_du,
  output logic             busy_du,
  output logic             done_du,
  output logic             exception_du
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDivide = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Sign- or zero-extend the low SEW bits to the full datapath.
  function automatic logic [WIDTH-1:0] ext_sew(input logic [WIDTH-1:0] x, input logic [1:0] s,
                                               input logic sgn);
    case (s)
      2'd0:    ext_sew = {{(WIDTH-8){sgn & x[7]}}, x[7:0]};
      2'd1:    ext_sew = {{(WIDTH-16){sgn & x[15]}}, x[15:0]};
      default: ext_sew = x;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mask_sew(input logic [WIDTH-1:0] x, input logic [1:0] s);
    case (s)
      2'd0:    mask_sew = {{(WIDTH-8){1'b0}}, x[7:0]};
      2'd1:    mask_sew = {{(WIDTH-16){1'b0}}, x[15:0]};
      default: mask_sew = x;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]       sew_q, sew_d;
  logic             div_type_q, div_type_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  // Operand preparation, evaluated in the start cycle.
  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, a_align, half;
  logic [CntW-1:0]  n_sew;
  logic             a_neg, b_neg, div_zero, sgn_ovf;

  always_comb begin
    a_ext = ext_sew(vs2_data, sew, is_signed_div);
    b_ext = ext_sew(vs1_data, sew, is_signed_div);
    a_neg = is_signed_div & a_ext[WIDTH-1];
    b_neg = is_signed_div & b_ext[WIDTH-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    // Dividend sits at the top of quo so its bits enter rem after exactly SEW shifts.
    case (sew)
      2'd0: begin
        a_align = {a_mag[7:0], {(WIDTH-8){1'b0}}};
        n_sew   = CntW'(8);
        half    = WIDTH'(1) << 7;
      end
      2'd1: begin
        a_align = {a_mag[15:0], {(WIDTH-16){1'b0}}};
        n_sew   = CntW'(16);
        half    = WIDTH'(1) << 15;
      end
      default: begin
        a_align = a_mag;
        n_sew   = CntW'(WIDTH);
        half    = WIDTH'(1) << (WIDTH - 1);
      end
    endcase
    div_zero = (b_ext == '0);
    // b_ext is all ones only for a sign-extended -1.
    sgn_ovf  = a_neg & (a_mag == half) & (b_ext == '1);
  end

  // One restoring step on the magnitudes.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub, rem_step, quo_step, q_fix, r_fix;
  logic             ge;

  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, dsr_q});
    // The difference is below the divisor, so modular WIDTH-bit subtraction is exact.
    rem_sub  = rem_sh[WIDTH-1:0] - dsr_q;
    rem_step = ge ? rem_sub : rem_sh[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ge};
    q_fix    = q_neg_q ? -quo_step : quo_step;
    r_fix    = r_neg_q ? -rem_step : rem_step;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    wdata_d    = wdata_q;
    sew_d      = sew_q;
    div_type_d = div_type_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    case (state_q)
      StIdle: begin
        if (start_div) begin
          cnt_d      = n_sew;
          rem_d      = '0;
          quo_d      = a_align;
          dsr_d      = b_mag;
          sew_d      = sew;
          div_type_d = div_type;
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          if (div_zero) begin
            state_d = StDone;
            wdata_d = div_type ? mask_sew(vs2_data, sew) : mask_sew('1, sew);
          end else if (sgn_ovf) begin
            state_d = StDone;
            wdata_d = div_type ? '0 : mask_sew(vs2_data, sew);
          end else begin
            state_d = StDivide;
          end
        end
      end
      StDivide: begin
        cnt_d = cnt_q - CntW'(1);
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          wdata_d = mask_sew(div_type_q ? r_fix : q_fix, sew_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      wdata_q    <= '0;
      sew_q      <= 2'd0;
      div_type_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      wdata_q    <= wdata_d;
      sew_q      <= sew_d;
      div_type_q <= div_type_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
    end
  end

  assign wdata_du     = wdata_q;
  assign busy_du      = (state_q != StIdle);
  assign done_du      = (state_q == StDone);
  assign exception_du = 1'b0;

endmodule

// File: tb/tb_vlane_div_unit.sv
module tb_vlane_div_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_div;
  logic [31:0] vs2_data, vs1_data;
  logic        div_type, is_signed_div;
  logic [1:0]  sew;
  logic [31:0] wdata_du;
  logic        busy_du, done_du, exception_du;

  vlane_div_unit #(.WIDTH(32)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start_div    (start_div),
    .vs2_data     (vs2_data),
    .vs1_data     (vs1_data),
    .div_type     (div_type),
    .is_signed_div(is_signed_div),
    .sew          (sew),
    .wdata_du     (wdata_du),
    .busy_du      (busy_du),
    .done_du      (done_du),
    .exception_du (exception_du)
  );

  always #5 CLK = ~CLK;

  int passes = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int sew_bits(input logic [1:0] w);
    return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
  endfunction

  // Interpret the low n bits of v as signed or unsigned integer.
  function automatic longint norm(input logic [31:0] v, input logic s, input int n);
    longint x, half;
    half = longint'(1) << (n - 1);
    x = longint'({32'b0, v}) & ((longint'(1) << n) - 1);
    if (s && x >= half) x = x - 2 * half;
    return x;
  endfunction

  function automatic bit ref_special(input logic [31:0] a, input logic [31:0] b, input logic s,
                                     input logic [1:0] w);
    int n = sew_bits(w);
    longint x = norm(a, s, n);
    longint y = norm(b, s, n);
    return (y == 0) || (s && x == -(longint'(1) << (n - 1)) && y == -1);
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic t, input logic s, input logic [1:0] w);
    int n = sew_bits(w);
    longint x = norm(a, s, n);
    longint y = norm(b, s, n);
    longint q, r;
    if (y == 0) begin
      q = -1; r = x;
    end else if (s && x == -(longint'(1) << (n - 1)) && y == -1) begin
      q = x; r = 0;
    end else begin
      q = x / y; r = x % y;
    end
    return 32'((t ? r : q) & ((longint'(1) << n) - 1));
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic [1:0] w);
    return ref_special(a, b, s, w) ? 1 : sew_bits(w) + 1;
  endfunction

  // m_left: cycles of occupancy still ahead; the done cycle is the one with m_left == 1.
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [31:0] exp_wdata = '0;
  bit          cmp_en = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_left    <= 0;
      exp_wdata <= '0;
    end else if (m_left == 0) begin
      if (start_div) begin
        m_left <= ref_lat(vs2_data, vs1_data, is_signed_div, sew);
        m_res  <= ref_div(vs2_data, vs1_data, div_type, is_signed_div, sew);
        if (ref_lat(vs2_data, vs1_data, is_signed_div, sew) == 1)
          exp_wdata <= ref_div(vs2_data, vs1_data, div_type, is_signed_div, sew);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) exp_wdata <= m_res;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("busy_du", {31'b0, busy_du}, {31'b0, m_left > 0});
      check("done_du", {31'b0, done_du}, {31'b0, m_left == 1});
      check("exception_du", {31'b0, exception_du}, 32'h0);
      check("wdata_du", wdata_du, exp_wdata);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic t, input logic s, input logic [1:0] w,
                        input logic [31:0] exp, input int lat);
    int k;
    @(negedge CLK);
    vs2_data = a; vs1_data = b; div_type = t; is_signed_div = s; sew = w; start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    // Scramble inputs: the unit must have latched them.
    vs2_data = $urandom; vs1_data = $urandom; div_type = ~t; is_signed_div = ~s;
    k = 1;
    while (done_du !== 1'b1 && k < 60) begin
      @(negedge CLK);
      k++;
    end
    check({name, " latency"}, k, lat);
    check({name, " result"}, wdata_du, exp);
  endtask

  initial begin
    int k, dones;
    RST = 1'b1; start_div = 1'b0; vs2_data = '0; vs1_data = '0;
    div_type = 1'b0; is_signed_div = 1'b0; sew = 2'd0;
    @(posedge CLK);
    cmp_en = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset wdata", wdata_du, 32'h0);
    check("reset busy", {31'b0, busy_du}, 32'h0);
    RST = 1'b0;

    run_op("s32 div", 32'hFFFFFFF9, 32'h2, 1'b0, 1'b1, 2'd2, 32'hFFFFFFFD, 33);
    run_op("s32 rem", 32'hFFFFFFF9, 32'h2, 1'b1, 1'b1, 2'd2, 32'hFFFFFFFF, 33);
    run_op("u16 div", 32'hABCD03E8, 32'h7, 1'b0, 1'b0, 2'd1, 32'h0000008E, 17);
    run_op("u16 rem", 32'hABCD03E8, 32'h7, 1'b1, 1'b0, 2'd1, 32'h00000006, 17);
    run_op("div0 quo", 32'h7, 32'h0, 1'b0, 1'b0, 2'd2, 32'hFFFFFFFF, 1);
    run_op("div0 rem", 32'h7, 32'h0, 1'b1, 1'b0, 2'd2, 32'h00000007, 1);
    run_op("ovf8 quo", 32'h80, 32'hFF, 1'b0, 1'b1, 2'd0, 32'h00000080, 1);
    run_op("ovf8 rem", 32'h80, 32'hFF, 1'b1, 1'b1, 2'd0, 32'h00000000, 1);

    // Start while busy and start in the done cycle are both ignored.
    @(negedge CLK);
    vs2_data = 32'd100; vs1_data = 32'd7; div_type = 1'b0; is_signed_div = 1'b0; sew = 2'd0;
    start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    k = 1; dones = 0;
    while (k < 3) begin @(negedge CLK); k++; end
    vs2_data = 32'd50; vs1_data = 32'd5; start_div = 1'b1;
    @(negedge CLK); k++;
    start_div = 1'b0;
    while (done_du !== 1'b1 && k < 60) begin @(negedge CLK); k++; end
    check("busy-start latency", k, 9);
    check("busy-start result", wdata_du, 32'h0000000E);
    start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    check("done-cycle start ignored", {31'b0, busy_du}, 32'h0);
    repeat (12) begin
      @(negedge CLK);
      if (done_du === 1'b1) dones++;
    end
    check("no extra done", dones, 0);

    // Reset in the middle of an SEW32 operation.
    @(negedge CLK);
    vs2_data = 32'd1000; vs1_data = 32'd3; div_type = 1'b0; is_signed_div = 1'b0; sew = 2'd2;
    start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst busy", {31'b0, busy_du}, 32'h0);
    check("rst wdata", wdata_du, 32'h0);
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done_du === 1'b1) dones++;
    end
    check("rst no done", dones, 0);
    run_op("post-rst u8", 32'd5, 32'd3, 1'b0, 1'b0, 2'd0, 32'h00000001, 9);

    // Randomized traffic, including starts while busy and occasional resets.
    repeat (3000) begin
      @(negedge CLK);
      sew = 2'($urandom_range(0, 3));
      div_type = 1'($urandom);
      is_signed_div = 1'($urandom);
      vs2_data = $urandom;
      case ($urandom_range(0, 7))
        0: vs1_data = {$urandom_range(0, 1) == 0 ? 16'h0 : 16'($urandom), 16'h0};
        1: begin
          vs1_data = 32'hFFFFFFFF;
          if (sew == 2'd0) vs2_data[7:0] = 8'h80;
          else if (sew == 2'd1) vs2_data[15:0] = 16'h8000;
          else vs2_data = 32'h80000000;
        end
        2: vs1_data = $urandom_range(1, 15);
        default: vs1_data = $urandom;
      endcase
      start_div = ($urandom_range(0, 3) == 0);
      RST = ($urandom_range(0, 299) == 0);
    end
    @(negedge CLK);
    RST = 1'b0; start_div = 1'b0;
    repeat (40) @(negedge CLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vlane_div_unit.md
Name: vlane_div_unit

Overview:
- Iterative integer divider that implements the responder side of the lane's divide handshake (start_div / done_du).
- It sits inside each vector lane, alongside the multiply and arithmetic units. The lane selects its result through wdata_du.
- It executes vdivu/vdiv/vremu/vrem per element at SEW 8/16/32 using one restoring-division step per cycle.
- Division by zero and signed overflow follow RISC-V non-trapping semantics.

Parameters:
- WIDTH, 32, datapath width in bits; it must equal the largest SEW.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- start_div  input  1  one-cycle request; sampled only in IDLE
- vs2_data  input  32  dividend (vd = vs2 op vs1); only the low SEW bits are used
- vs1_data  input  32  divisor; only the low SEW bits are used
- div_type  input  1  0 = quotient, 1 = remainder
- is_signed_div  input  1  1 = two's-complement operands
- sew  input  2  00 = 8, 01 = 16, 10 = 32; 11 is reserved and treated as 32
- wdata_du  output  32  result in the low SEW bits, upper bits zero
- busy_du  output  1  unit occupied
- done_du  output  1  one-cycle result-valid pulse
- exception_du  output  1  always 0 (division never traps)

Behaviour:
- Reset (RST high on a rising edge):
  - state returns to IDLE;
  - wdata_du, busy_du, done_du and exception_du are all 0;
  - an operation in flight is discarded with no done_du pulse.
- States: IDLE, DIVIDE, DONE.
- IDLE:
  - busy_du = 0, done_du = 0.
  - When start_div = 1, the unit latches the operands, div_type, is_signed_div and sew. The inputs need not be held after this cycle.
  - Operand extension: in signed mode operands are sign-extended from SEW; otherwise they are zero-extended.
  - The unit records the magnitudes, the dividend sign and the quotient sign (the XOR of the operand signs).
  - Iteration counter is loaded with N = SEW.
  - Next state is DIVIDE, unless a special case applies, in which case the next state is DONE.
- Special cases (detected at start; the unit goes directly to DONE with the result precomputed):
  - divisor == 0: quotient = all ones (SEW bits); remainder = dividend (SEW bits).
  - signed, dividend == -2^(SEW-1), divisor == -1: quotient = dividend (SEW bits); remainder = 0.
- DIVIDE:
  - busy_du = 1.
  - Each cycle performs one restoring step on the magnitudes:
    - shift {rem, quo} left by 1;
    - if rem >= divisor magnitude, subtract it and set the quo LSB to 1;
    - decrement the counter.
  - After N steps (counter reaches 0) the next state is DONE.
- DONE (exactly one cycle):
  - busy_du = 1, done_du = 1.
  - Sign fixup in signed mode: the quotient is negated if the quotient sign is 1; the remainder is negated if the dividend was negative.
  - wdata_du = selected result masked to SEW bits, updated on the same edge that enters DONE.
  - Next state is IDLE.
- Latency:
  - start in cycle T → DONE (done_du = 1) in cycle T+N+1, i.e. 9, 17 or 33 cycles after start.
  - Special case: DONE in T+1.
- wdata_du holds its value after DONE until the next DONE or reset.
- start_div asserted while busy_du = 1 is ignored; no queueing. The lane must wait for done_du.
- start_div in the DONE cycle is ignored; a new start is accepted from IDLE, i.e. the cycle after done_du at the earliest.
- RST has priority over start_div in the same cycle.

Test Plan:
- Signed 32-bit: vs2 = 0xFFFFFFF9 (-7), vs1 = 2, signed.
  - div_type = 0 → wdata_du = 0xFFFFFFFD.
  - div_type = 1 → wdata_du = 0xFFFFFFFF.
  - done_du arrives exactly 33 cycles after start; busy_du is high from T+1 through T+33.
- Unsigned SEW16: vs2 = 0xABCD03E8, vs1 = 0x00000007.
  - Quotient → 0x0000008E; remainder → 0x00000006.
  - done_du arrives 17 cycles after start; the upper bits of the inputs are ignored.
- Divide by zero, SEW32 unsigned: vs2 = 7, vs1 = 0.
  - Quotient → 0xFFFFFFFF; remainder → 0x00000007.
  - done_du arrives at T+1; exception_du stays 0.
- Signed overflow, SEW8: vs2 = 0x80, vs1 = 0xFF.
  - Quotient → 0x00000080; remainder → 0x00000000.
  - done_du arrives at T+1.
- Start while busy: a second start_div with different operands at T+4 of an SEW8 op is ignored → single done_du at T+9 with the first operation's result. A start in the done_du cycle is also ignored.
- Reset mid-operation: RST pulsed at T+5 of an SEW32 op → busy_du = 0, wdata_du = 0, and no done_du. A new op started after reset (5/3 unsigned, SEW8) → quotient 0x00000001 after 9 cycles.
